// File: rtl/conv_mem_arbiter.sv
// Arbiter for one single-port image/result RAM shared by the scan engine writeback,
// scan engine window reads and the host loader. Handles aging, burst locks and read-return tagging.
module conv_mem_arbiter #(
    parameter int AW         = 14,
    parameter int DW         = 8,
    parameter int STARVE_MAX = 8,
    parameter int LOCK_MAX   = 9
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [2:0]    req,
    input  logic [2:0]    we,
    input  logic [2:0]    lock,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [AW-1:0] addr2,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    input  logic [DW-1:0] wdata2,
    output logic [2:0]    gnt,
    output logic [2:0]    rvalid,
    output logic [DW-1:0] rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          starve_flag
);

    localparam int AGW = $clog2(STARVE_MAX + 1);
    localparam int CW  = $clog2(LOCK_MAX + 1);

    typedef enum logic {S_IDLE, S_LOCKED} state_t;

    state_t          r_state;
    logic [1:0]      r_owner;
    logic [CW-1:0]   r_lock_cnt;
    logic            r_demote_vld;
    logic [1:0]      r_demote_idx;
    logic [AGW-1:0]  r_age [3];
    logic            r_p1_vld;
    logic            r_p2_vld;
    logic [1:0]      r_p1_tag;
    logic [1:0]      r_p2_tag;

    logic [2:0]      w_promoted;
    logic [2:0]      w_gnt;
    logic [1:0]      w_gnt_idx;
    logic [AW-1:0]   w_addr  [3];
    logic [DW-1:0]   w_wdata [3];

    assign w_addr[0]  = addr0;
    assign w_addr[1]  = addr1;
    assign w_addr[2]  = addr2;
    assign w_wdata[0] = wdata0;
    assign w_wdata[1] = wdata1;
    assign w_wdata[2] = wdata2;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_age
            assign w_promoted[gi] = req[gi] && (r_age[gi] >= AGW'(STARVE_MAX));

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_age[gi] <= '0;
                end else if (!req[gi] || w_gnt[gi]) begin
                    r_age[gi] <= '0;
                end else if (r_age[gi] < AGW'(STARVE_MAX)) begin
                    r_age[gi] <= r_age[gi] + 1'b1;
                end
            end
        end
    endgenerate

    // Downward scans let the lowest qualifying index overwrite higher ones.
    always_comb begin
        w_gnt = '0;
        if (rst) begin
            w_gnt = '0;
        end else if (r_state == S_LOCKED) begin
            w_gnt[r_owner] = req[r_owner];
        end else if (|w_promoted) begin
            for (int i = 2; i >= 0; i--) begin
                if (w_promoted[i]) w_gnt = 3'b001 << i;
            end
        end else begin
            for (int i = 2; i >= 0; i--) begin
                if (req[i] && !(r_demote_vld && r_demote_idx == 2'(i))) w_gnt = 3'b001 << i;
            end
            if (w_gnt == 3'b000 && r_demote_vld && req[r_demote_idx]) begin
                w_gnt[r_demote_idx] = 1'b1;
            end
        end
    end

    always_comb begin
        w_gnt_idx = 2'd0;
        if (w_gnt[1]) w_gnt_idx = 2'd1;
        if (w_gnt[2]) w_gnt_idx = 2'd2;
    end

    assign gnt = w_gnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_owner      <= '0;
            r_lock_cnt   <= '0;
            r_demote_vld <= 1'b0;
            r_demote_idx <= '0;
            r_p1_vld     <= 1'b0;
            r_p1_tag     <= '0;
            r_p2_vld     <= 1'b0;
            r_p2_tag     <= '0;
            rvalid       <= '0;
            rdata        <= '0;
            mem_en       <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            starve_flag  <= 1'b0;
        end else begin
            r_demote_vld <= 1'b0;

            mem_en <= |w_gnt;
            mem_we <= (|w_gnt) && we[w_gnt_idx];
            if (|w_gnt) begin
                mem_addr  <= w_addr[w_gnt_idx];
                mem_wdata <= w_wdata[w_gnt_idx];
            end

            // Read tag travels two stages to line up with the RAM's registered output.
            r_p1_vld <= (|w_gnt) && !we[w_gnt_idx];
            r_p1_tag <= w_gnt_idx;
            r_p2_vld <= r_p1_vld;
            r_p2_tag <= r_p1_tag;
            rvalid   <= r_p2_vld ? (3'b001 << r_p2_tag) : 3'b000;
            if (r_p2_vld) rdata <= mem_rdata;

            if (|w_promoted) starve_flag <= 1'b1;

            case (r_state)
                S_IDLE: begin
                    if ((|w_gnt) && lock[w_gnt_idx]) begin
                        r_state    <= S_LOCKED;
                        r_owner    <= w_gnt_idx;
                        r_lock_cnt <= CW'(1);
                    end
                end
                S_LOCKED: begin
                    if (!lock[r_owner]) begin
                        r_state <= S_IDLE;
                    end else if (r_lock_cnt >= CW'(LOCK_MAX - 1)) begin
                        r_state      <= S_IDLE;
                        r_demote_vld <= 1'b1;
                        r_demote_idx <= r_owner;
                    end else begin
                        r_lock_cnt <= r_lock_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_mem_arbiter.sv
// Self-checking bench for conv_mem_arbiter: directed arbitration sequences with a
// read-return scoreboard fed from the bench's own expected grants and memory model.
module tb_conv_mem_arbiter;

    localparam int AW = 14;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [2:0]    req, we, lock;
    logic [AW-1:0] addr0, addr1, addr2;
    logic [DW-1:0] wdata0, wdata1, wdata2;
    logic [2:0]    gnt, rvalid;
    logic [DW-1:0] rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          starve_flag;

    conv_mem_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(8), .LOCK_MAX(9)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .lock(lock),
        .addr0(addr0), .addr1(addr1), .addr2(addr2),
        .wdata0(wdata0), .wdata1(wdata1), .wdata2(wdata2),
        .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .starve_flag(starve_flag)
    );

    always #5 clk = ~clk;

    // RAM macro model
    logic [DW-1:0] ram [1 << AW];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [1:0]    tag;
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    exp_t          sb [$];
    logic [DW-1:0] model_mem [1 << AW];
    int            n_checks = 0;
    int            n_errors = 0;

    logic          prev_vld = 1'b0;
    logic          prev_we;
    logic [AW-1:0] prev_addr;
    logic [DW-1:0] prev_wd;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [AW-1:0] addr_of(input int k);
        return (k == 0) ? addr0 : (k == 1) ? addr1 : addr2;
    endfunction

    function automatic logic [DW-1:0] wdata_of(input int k);
        return (k == 0) ? wdata0 : (k == 1) ? wdata1 : wdata2;
    endfunction

    // Check this cycle's grant and the command issued for the previous expected grant.
    task automatic cycle_chk(input logic [2:0] exp_gnt);
        int k;
        @(negedge clk);
        check_val("gnt", {29'd0, gnt}, {29'd0, exp_gnt});
        check_val("mem_en", {31'd0, mem_en}, {31'd0, prev_vld});
        if (prev_vld) begin
            check_val("mem_we", {31'd0, mem_we}, {31'd0, prev_we});
            check_val("mem_addr", {18'd0, mem_addr}, {18'd0, prev_addr});
            if (prev_we) check_val("mem_wdata", {24'd0, mem_wdata}, {24'd0, prev_wd});
        end
        prev_vld = (exp_gnt != 3'b000);
        if (prev_vld) begin
            k = exp_gnt[0] ? 0 : exp_gnt[1] ? 1 : 2;
            prev_we   = we[k];
            prev_addr = addr_of(k);
            prev_wd   = wdata_of(k);
            if (we[k]) begin
                model_mem[prev_addr] = prev_wd;
                $display("grant r%0d write addr=%04h data=%02h", k, prev_addr, prev_wd);
            end else begin
                sb.push_back('{tag: 2'(k), data: model_mem[prev_addr], due: cyc + 3});
                $display("grant r%0d read  addr=%04h", k, prev_addr);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs_zero(input string tag);
        check_val({tag, "_gnt"}, {29'd0, gnt}, 32'd0);
        check_val({tag, "_rvalid"}, {29'd0, rvalid}, 32'd0);
        check_val({tag, "_rdata"}, {24'd0, rdata}, 32'd0);
        check_val({tag, "_mem"}, {mem_en, mem_we, mem_addr, mem_wdata, starve_flag},
                  {1'b0, 1'b0, 14'd0, 8'd0, 1'b0});
    endtask

    always @(negedge clk) begin
        if (!rst && rvalid != 3'b000) begin
            if (sb.size() == 0) begin
                check_val("rvalid_unexpected", {29'd0, rvalid}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                $display("rvalid %b data=%02h", rvalid, rdata);
                check_val("rvalid_tag", {29'd0, rvalid}, {29'd0, 3'b001 << e.tag});
                check_val("rdata", {24'd0, rdata}, {24'd0, e.data});
                check_val("rvalid_latency", cyc, e.due);
            end
        end
    end

    logic [AW-1:0] win [9];

    initial begin
        win = '{14'd0, 14'd1, 14'd2, 14'd50, 14'd51, 14'd52, 14'd100, 14'd101, 14'd102};
        rst = 1'b1; req = 3'b111; we = 3'b000; lock = 3'b000;
        addr0 = '0; addr1 = '0; addr2 = '0; wdata0 = '0; wdata1 = '0; wdata2 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_outputs_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0; req = 3'b000;

        // Single write then read by the host, read followed directly by a write
        req = 3'b100; we = 3'b100; addr2 = 14'h0032; wdata2 = 8'hA5;
        cycle_chk(3'b100);
        we = 3'b000;
        cycle_chk(3'b100);
        we = 3'b100; addr2 = 14'h0033; wdata2 = 8'h3C;
        cycle_chk(3'b100);
        req = 3'b000;
        repeat (3) cycle_chk(3'b000);

        // Fixed priority, all writes
        req = 3'b111; we = 3'b111;
        addr0 = 14'h0100; wdata0 = 8'h11; addr1 = 14'h0101; wdata1 = 8'h22; addr2 = 14'h0102; wdata2 = 8'h33;
        cycle_chk(3'b001);
        req = 3'b110;
        cycle_chk(3'b010);
        req = 3'b100;
        cycle_chk(3'b100);
        req = 3'b000;
        cycle_chk(3'b000);

        // Starvation: R0 requests every cycle, R2 held
        req = 3'b101; we = 3'b101; addr2 = 14'h0200; wdata2 = 8'h77;
        for (int i = 0; i < 8; i++) begin
            addr0 = 14'(14'h0300 + i); wdata0 = 8'(i);
            if (i == 7) check_val("starve_flag_pre", {31'd0, starve_flag}, 32'd0);
            cycle_chk(3'b001);
        end
        cycle_chk(3'b100);
        req = 3'b001;
        check_val("starve_flag_set", {31'd0, starve_flag}, 32'd1);
        cycle_chk(3'b001);
        req = 3'b000;
        cycle_chk(3'b000);

        // Preload window addresses through the host port
        req = 3'b100; we = 3'b100;
        for (int i = 0; i < 9; i++) begin
            addr2 = win[i]; wdata2 = 8'(i * 29 + 7);
            cycle_chk(3'b100);
        end
        req = 3'b000;
        cycle_chk(3'b000);

        // Window burst: R1 locks, R0 requests from the second cycle on
        we = 3'b001; lock = 3'b010; addr0 = 14'h0400; wdata0 = 8'hC3;
        for (int i = 0; i < 9; i++) begin
            req = (i == 0) ? 3'b010 : 3'b011;
            addr1 = win[i];
            cycle_chk(3'b010);
        end
        req = 3'b001; lock = 3'b000;
        cycle_chk(3'b001);
        req = 3'b000;
        repeat (2) cycle_chk(3'b000);

        // Forced release: R1 holds lock past nine grants, R2 reads from the fourth cycle
        we = 3'b000; lock = 3'b010; addr2 = 14'h0032;
        for (int i = 0; i < 9; i++) begin
            req = (i < 3) ? 3'b010 : 3'b110;
            addr1 = win[8 - i];
            cycle_chk(3'b010);
        end
        addr1 = win[4];
        cycle_chk(3'b100);
        req = 3'b010; lock = 3'b000;
        cycle_chk(3'b010);
        req = 3'b000;
        repeat (3) cycle_chk(3'b000);
        check_val("starve_flag_sticky", {31'd0, starve_flag}, 32'd1);

        // Reset one cycle after a read grant
        req = 3'b100; we = 3'b000; addr2 = 14'h0032;
        cycle_chk(3'b100);
        req = 3'b000;
        rst = 1'b1;
        sb.delete();
        prev_vld = 1'b0;
        @(negedge clk);
        check_outputs_zero("midreset");
        @(posedge clk); #1;
        @(negedge clk);
        check_outputs_zero("midreset2");
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) cycle_chk(3'b000);
        req = 3'b001; we = 3'b000; addr0 = 14'h0033;
        cycle_chk(3'b001);
        req = 3'b000;
        repeat (4) cycle_chk(3'b000);

        check_val("scoreboard_drained", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/conv_mem_arbiter.md
Name: conv_mem_arbiter

Overview:
- Arbitrates one single-port image/result RAM (14-bit address, 8-bit data, 1-cycle read latency) between three requesters:
  - R0: result writeback from the convolution scan engine.
  - R1: window reads from the scan engine.
  - R2: host frame loader/unloader.
- Provides per-requester request/grant handshakes, starvation aging, a burst lock for 3x3 window fetches, and read-data return tagging.
- Sits between the scan engine, the host interface and the RAM macro.

Parameters:
- AW, 14, address width.
- DW, 8, data width.
- STARVE_MAX, 8, consecutive waiting cycles before a requester is promoted to top priority.
- LOCK_MAX, 9, maximum consecutive grants held by one lock.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req[2:0]  in  3  request per requester; held until granted.
- we[2:0]  in  3  per-requester write enable (1 = write, 0 = read).
- lock[2:0]  in  3  per-requester burst lock; only sampled while that requester owns the port.
- addr0, addr1, addr2  in  AW each  per-requester address.
- wdata0, wdata1, wdata2  in  DW each  per-requester write data.
- gnt[2:0]  out  3  one-hot grant; combinational; the request is accepted at the rising edge where gnt=1.
- rvalid[2:0]  out  3  one-hot read-return strobe; registered.
- rdata  out  DW  read data, valid when any rvalid bit is 1.
- mem_en  out  1  RAM enable; registered.
- mem_we  out  1  RAM write enable; registered.
- mem_addr  out  AW  RAM address; registered.
- mem_wdata  out  DW  RAM write data; registered.
- mem_rdata  in  DW  RAM read data; valid one cycle after mem_en with mem_we=0.
- starve_flag  out  1  sticky; set when any promotion occurs; cleared only by rst.

Behaviour:
- Reset values: gnt=0, rvalid=0, rdata=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, starve_flag=0. All age counters, the lock owner and the lock counter clear. Reset mid-operation discards in-flight reads; no rvalid pulse follows the reset.
- States: IDLE (no owner) and LOCKED (owner holds the port).
- Grant selection, IDLE:
  - Base priority is R0 > R1 > R2.
  - Any requester with age >= STARVE_MAX overrides base priority.
  - If several are promoted, the lowest index among the promoted wins.
  - At most one gnt bit is ever high.
  - gnt is never asserted to a requester whose req is 0.
- Transition to LOCKED: occurs at the edge where the granted requester has lock=1. The lock counter is loaded to 1.
- While LOCKED:
  - gnt goes only to the owner, whenever owner req=1; aging promotion is ignored.
  - Each owner grant increments the lock counter.
  - Return to IDLE when the owner drops lock, or when the lock counter reaches LOCK_MAX. The forced release takes effect after the LOCK_MAX-th grant.
  - After a forced release, the former owner gets lowest priority for one arbitration cycle.
  - Owner req=0 with lock=1: no grant is issued and the port stays reserved. The cycle counts toward LOCK_MAX.
- Aging:
  - A requester's age increments each cycle it has req=1 and gnt=0, saturating at STARVE_MAX.
  - Age clears to 0 on grant, and when req=0.
- Memory issue: at the edge after gnt[k]=1, the mem_* outputs carry requester k's command (mem_en=1, mem_we=we[k], addr, wdata). mem_en=0 in cycles with no grant.
- Read return: for a granted read at edge N, mem_en is high in cycle N+1 and mem_rdata is valid in cycle N+2. rdata and rvalid[k] are registered at edge N+2, so total latency from grant edge to rvalid is 2 cycles.
- Pipelining: back-to-back reads from the same or different requesters are fully pipelined at one per cycle. rvalid order matches grant order.
- Write response: writes produce no rvalid.
- Simultaneous events:
  - A grant in the same cycle as a returning read is allowed.
  - A write issued directly after a read does not corrupt that read's return.
  - A requester may re-request in the cycle after its grant, with no bubble.
- Address and data pass through unmodified; no width conversion.

Test Plan:
- Reset then single access: rst pulse; R2 writes addr=0x0032, data=0xA5; then R2 reads 0x0032. Required: gnt[2]=1 on the first request cycle; mem_we=1 with mem_addr=0x0032 the next cycle; rvalid[2]=1 and rdata=0xA5 two cycles after the read grant.
- Fixed priority: req=3'b111, all writes, for 3 cycles. Required: gnt sequence 001, 010, 100 as each requester drops req after its grant.
- Starvation: R0 requests every cycle and R2 holds req from cycle 0. Required: gnt[2]=1 exactly when R2's age reaches 8; starve_flag goes to 1 and stays 1.
- Window burst: R1 locks and reads addresses 0, 1, 2, 50, 51, 52, 100, 101, 102 while R0 requests. Required: nine consecutive gnt[1] and no gnt[0] during the burst; nine rvalid[1] pulses with matching data; gnt[0] on the cycle after the ninth grant.
- Forced release: R1 keeps lock=1 past 9 grants while R2 requests. Required: R2 is granted immediately after R1's ninth grant; R1 regains the port later.
- Reset mid-read: assert rst one cycle after a read grant. Required: no rvalid pulse; all outputs are 0 while rst=1; normal arbitration resumes after deassertion.
